// File: rtl/decoder_pkg.sv
// Shared decode definitions for the ID stage.
//   - MIPS opcode / funct constants used by the decoder
//   - addr_type and mem_size encodings
//   - dec_t: packed decode bundle handed to the control unit
//   - pipe_state_e: pipeline-register occupancy {out_valid, skid_valid}
package decoder_pkg;

  localparam int REG_W = 5;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;

  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRA  = 6'b000011;
  localparam logic [5:0] FUNC_SLLV = 6'b000100;
  localparam logic [5:0] FUNC_SRLV = 6'b000110;
  localparam logic [5:0] FUNC_SRAV = 6'b000111;
  localparam logic [5:0] FUNC_JR   = 6'b001000;
  localparam logic [5:0] FUNC_JALR = 6'b001001;
  localparam logic [5:0] FUNC_ADDU = 6'b100001;
  localparam logic [5:0] FUNC_SUBU = 6'b100011;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_NOR  = 6'b100111;
  localparam logic [5:0] FUNC_SLT  = 6'b101010;

  localparam logic [1:0] AT_REG    = 2'b00;  // target from register
  localparam logic [1:0] AT_REGION = 2'b01;  // 26-bit in-region jump
  localparam logic [1:0] AT_PCREL  = 2'b10;  // PC-relative 16-bit branch

  localparam logic [1:0] MS_BYTE   = 2'b00;
  localparam logic [1:0] MS_HALF   = 2'b01;
  localparam logic [1:0] MS_WORD   = 2'b11;

  typedef struct packed {
    logic [5:0]       funct;
    logic [25:0]      addr_offset;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] shamt;
    logic             pc_modify;
    logic             link_ret;
    logic [1:0]       addr_type;
    logic [REG_W-1:0] link_reg;
    logic [REG_W-1:0] addr_reg;
    logic             equal;
    logic             inmediate;
    logic             mem_op;
    logic             mem_type;
    logic [1:0]       mem_size;
    logic             unsign;
    logic             illegal;
  } dec_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b10,
    ST_FULL  = 2'b11
  } pipe_state_e;

endpackage

// File: rtl/decode_logic.sv
// Purely combinational MIPS instruction decoder.
//   instr_i : raw 32-bit instruction word
//   dec_o   : decoded field/flag bundle (illegal words keep their raw
//             fields but carry no control flags)
module decode_logic
  import decoder_pkg::*;
#(
  parameter int RA_REG = 31
) (
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] op, fn;
  logic       bad;

  assign op = instr_i[31:26];
  assign fn = instr_i[5:0];

  always_comb begin
    dec_o             = '0;
    bad               = 1'b0;
    dec_o.funct       = fn;
    dec_o.addr_offset = instr_i[25:0];
    dec_o.rs          = instr_i[25:21];
    dec_o.rt          = instr_i[20:16];
    dec_o.rd          = instr_i[15:11];
    dec_o.shamt       = instr_i[10:6];

    casez (op)
      OP_RTYPE: begin
        case (fn)
          FUNC_JR: begin
            dec_o.pc_modify = 1'b1;
            dec_o.addr_type = AT_REG;
            dec_o.addr_reg  = instr_i[25:21];
          end
          FUNC_JALR: begin
            dec_o.pc_modify = 1'b1;
            dec_o.addr_type = AT_REG;
            dec_o.addr_reg  = instr_i[25:21];
            dec_o.link_ret  = 1'b1;
            dec_o.link_reg  = instr_i[15:11];
          end
          FUNC_SLL, FUNC_SRL, FUNC_SRA, FUNC_SLLV, FUNC_SRLV, FUNC_SRAV,
          FUNC_ADDU, FUNC_SUBU, FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR,
          FUNC_SLT: ;
          default: bad = 1'b1;
        endcase
      end
      OP_J, OP_JAL: begin
        dec_o.pc_modify = 1'b1;
        dec_o.addr_type = AT_REGION;
        dec_o.link_ret  = op[0];
        dec_o.link_reg  = REG_W'(RA_REG);
      end
      OP_BEQ, OP_BNE: begin
        dec_o.pc_modify = 1'b1;
        dec_o.addr_type = AT_PCREL;
        dec_o.equal     = ~op[0];
      end
      6'b001???: begin
        // ALU-immediate ops carry their operation in the low opcode bits
        dec_o.inmediate = 1'b1;
        dec_o.funct     = {3'b000, op[2:0]};
      end
      6'b10????: begin
        // op[3]=store, op[2]=unsigned, op[1:0]=size; 10 size and
        // unsigned stores have no encoding
        dec_o.mem_op   = 1'b1;
        dec_o.mem_type = op[3];
        dec_o.mem_size = op[1:0];
        dec_o.unsign   = op[2];
        bad = (op[1:0] == 2'b10) || (op[3] && op[2]);
      end
      default: bad = 1'b1;
    endcase

    if (bad) begin
      dec_o.pc_modify = 1'b0;
      dec_o.link_ret  = 1'b0;
      dec_o.addr_type = '0;
      dec_o.link_reg  = '0;
      dec_o.addr_reg  = '0;
      dec_o.equal     = 1'b0;
      dec_o.inmediate = 1'b0;
      dec_o.mem_op    = 1'b0;
      dec_o.mem_type  = 1'b0;
      dec_o.mem_size  = '0;
      dec_o.unsign    = 1'b0;
      dec_o.funct     = fn;
      dec_o.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/instruction_decoder.sv
// ID stage: combinational decode into a valid/ready output register with a
// one-entry skid buffer. o_ready is registered; i_flush empties the stage
// and drops any same-cycle input; i_reset (sync, active high) wins over all.
// Ports: i_clk/i_reset, fetch side i_instr/i_valid/o_ready, i_flush,
// downstream o_valid/i_ready plus the decoded field/flag outputs.
module instruction_decoder
  import decoder_pkg::*;
#(
  parameter int INSTR_W = 32,
  parameter int REG_W   = 5,
  parameter int RA_REG  = 31
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [5:0]         o_funct,
  output logic [25:0]        o_addr_offset,
  output logic [REG_W-1:0]   o_rs,
  output logic [REG_W-1:0]   o_rt,
  output logic [REG_W-1:0]   o_rd,
  output logic [REG_W-1:0]   o_shamt,
  output logic               o_flg_pc_modify,
  output logic               o_flg_link_ret,
  output logic [1:0]         o_flg_addr_type,
  output logic [REG_W-1:0]   o_link_reg,
  output logic [REG_W-1:0]   o_addr_reg,
  output logic               o_flg_equal,
  output logic               o_flg_inmediate,
  output logic               o_flg_mem_op,
  output logic               o_flg_mem_type,
  output logic               o_flg_unsign,
  output logic [1:0]         o_flg_mem_size,
  output logic               o_illegal
);

  dec_t        dec;
  dec_t        out_q, out_d, skid_q, skid_d;
  pipe_state_e state_q, state_d;
  logic        ready_q;
  logic        accept, taken;

  decode_logic #(.RA_REG(RA_REG)) u_dec (
    .instr_i (i_instr[31:0]),
    .dec_o   (dec)
  );

  assign accept = i_valid & ready_q;
  assign taken  = state_q[1] & i_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          state_d = ST_BUSY;
          out_d   = dec;
        end
        ST_BUSY: begin
          if (taken && accept) begin
            out_d = dec;
          end else if (taken) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = dec;
          end
        end
        ST_FULL: if (taken) begin
          // ready_q is low here, so no new word can arrive this cycle
          state_d = ST_BUSY;
          out_d   = skid_q;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ~state_d[0];
    end
  end

  assign o_ready         = ready_q;
  assign o_valid         = state_q[1];
  assign o_funct         = out_q.funct;
  assign o_addr_offset   = out_q.addr_offset;
  assign o_rs            = out_q.rs;
  assign o_rt            = out_q.rt;
  assign o_rd            = out_q.rd;
  assign o_shamt         = out_q.shamt;
  assign o_flg_pc_modify = out_q.pc_modify;
  assign o_flg_link_ret  = out_q.link_ret;
  assign o_flg_addr_type = out_q.addr_type;
  assign o_link_reg      = out_q.link_reg;
  assign o_addr_reg      = out_q.addr_reg;
  assign o_flg_equal     = out_q.equal;
  assign o_flg_inmediate = out_q.inmediate;
  assign o_flg_mem_op    = out_q.mem_op;
  assign o_flg_mem_type  = out_q.mem_type;
  assign o_flg_unsign    = out_q.unsign;
  assign o_flg_mem_size  = out_q.mem_size;
  assign o_illegal       = out_q.illegal;

endmodule
